spongent_perm_inv: RTL and testbench

- Iterative inverse SPONGENT permutation engine: one inverse round per clock.
- Per round: inverse P-layer, then inverse S-box layer, then round-counter XOR removal, with the round LFSR stepped backward.
- Sits beside the forward SPONGENT datapath. Undoes a full permutation for decryption/unwrap and for self-test of the forward core.
- Valid/ready handshake on both sides.

---
 rtl/spongent_pkg.sv | 59 +++++
 rtl/spongent_perm_inv_if.sv | 42 ++++
 rtl/spongent_player_inv.sv | 26 ++
 rtl/spongent_perm_inv.sv | 162 ++++++++++++++++
 tb/tb_spongent_perm_inv.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/spongent_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spongent_pkg
//  Description : Shared SPONGENT definitions: forward/inverse S-box tables,
//                round-counter LFSR step functions (forward and backward),
//                elaboration-time computation of the last round's counter
//                value, and the permutation engine FSM encodings.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package spongent_pkg;

    // The LFSR taps (bits 6 and 5) fix the round counter at 7 bits.
    typedef logic [6:0] lcnt_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] SBOX_FWD [16] = '{
        4'hE, 4'hD, 4'hB, 4'h0, 4'h2, 4'h1, 4'h4, 4'hF,
        4'h7, 4'hA, 4'h8, 4'h5, 4'h9, 4'hC, 4'h3, 4'h6
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'h3, 4'h5, 4'h4, 4'hE, 4'h6, 4'hB, 4'hF, 4'h8,
        4'hA, 4'hC, 4'h9, 4'h2, 4'hD, 4'h1, 4'h0, 4'h7
    };

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        return SBOX_FWD[x];
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        return SBOX_INV[x];
    endfunction

    function automatic lcnt_t lfsr_fwd(input lcnt_t s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    // Undoes lfsr_fwd: the dropped MSB is recovered from the feedback bit.
    function automatic lcnt_t lfsr_back(input lcnt_t s);
        return {s[0] ^ s[6], s[6:1]};
    endfunction

    // Counter value used by the final forward round, i.e. the first value
    // the inverse engine needs.
    function automatic lcnt_t lcnt_last(input lcnt_t init, input int unsigned steps);
        lcnt_t s;
        s = init;
        for (int unsigned k = 0; k < steps; k++) begin
            s = lfsr_fwd(s);
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spongent_perm_inv_if.sv
`default_nettype none
// ============================================================================
//  Module      : spongent_perm_inv_if
//  Description : Valid/ready handshake bundle for the SPONGENT permutation
//                engine. Optional macro SPONGENT_PERM_INV_FWD_EN adds the
//                1-bit mode signal (1 = forward permutation).
//  Signals     : in_valid/in_ready/data_in   - state input handshake
//                out_valid/out_ready/data_out - result output handshake
//                mode (macro only)            - direction, sampled on accept
//  Modports    : master (producer/consumer side), slave (engine side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface spongent_perm_inv_if #(
    parameter int SPONGENT_B = 136
);
    logic                  in_valid;
    logic                  in_ready;
    logic [SPONGENT_B-1:0] data_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [SPONGENT_B-1:0] data_out;
`ifdef SPONGENT_PERM_INV_FWD_EN
    logic                  mode;
`endif

    modport master (
        output in_valid, data_in, out_ready,
`ifdef SPONGENT_PERM_INV_FWD_EN
        output mode,
`endif
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, out_ready,
`ifdef SPONGENT_PERM_INV_FWD_EN
        input  mode,
`endif
        output in_ready, out_valid, data_out
    );
endinterface
`default_nettype wire

// File: rtl/spongent_player_inv.sv
`default_nettype none
// ============================================================================
//  Module      : spongent_player_inv
//  Description : Combinational inverse SPONGENT bit permutation.
//                out[i] = in[(i*b/4) mod (b-1)] for i < b-1, MSB passes.
//  Ports       : in_x  [SPONGENT_B] - state before inverse P-layer
//                out_x [SPONGENT_B] - state after inverse P-layer
//  Revision    : 1.0 - initial release
// ============================================================================
module spongent_player_inv #(
    parameter int SPONGENT_B = 136
) (
    input  logic [SPONGENT_B-1:0] in_x,
    output logic [SPONGENT_B-1:0] out_x
);
    genvar i;
    generate
        for (i = 0; i < SPONGENT_B - 1; i++) begin : g_bit
            localparam int SRC = (i * (SPONGENT_B / 4)) % (SPONGENT_B - 1);
            assign out_x[i] = in_x[SRC];
        end
    endgenerate

    assign out_x[SPONGENT_B-1] = in_x[SPONGENT_B-1];
endmodule
`default_nettype wire

// File: rtl/spongent_perm_inv.sv
`default_nettype none
// ============================================================================
//  Module      : spongent_perm_inv
//  Description : Iterative inverse SPONGENT permutation, one round per clock.
//                Round = inverse P-layer, inverse S-box layer, counter XOR;
//                the counter LFSR steps backward from the last forward value.
//                Macro SPONGENT_PERM_INV_FWD_EN adds a forward mode
//                (counter XOR, S-box, P-layer, LFSR stepping forward).
//  Ports       : clk   - clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - spongent_perm_inv_if.slave handshake bundle
//  Revision    : 1.0 - initial release
// ============================================================================
import spongent_pkg::*;

module spongent_perm_inv #(
    parameter int              SPONGENT_B = 136,
    parameter int              SPONGENT_R = 70,
    parameter int              LCNT_W     = 7,
    parameter logic [LCNT_W-1:0] LCNT_INIT = 7'h7A
) (
    input  logic                     clk,
    input  logic                     rst_n,
    spongent_perm_inv_if.slave       bus
);
    localparam int RND_W = $clog2(SPONGENT_R);
    localparam logic [LCNT_W-1:0] LCNT_LAST = lcnt_last(LCNT_INIT, SPONGENT_R - 1);

    logic [1:0]            st_q, st_d;
    logic [SPONGENT_B-1:0] state_q, state_d;
    logic [RND_W-1:0]      rnd_q, rnd_d;
    logic [LCNT_W-1:0]     lcnt_q, lcnt_d;

    logic [LCNT_W-1:0]     w_lcnt_rev;
    logic [SPONGENT_B-1:0] w_pinv;
    logic [SPONGENT_B-1:0] w_sinv;
    logic [SPONGENT_B-1:0] w_inv_round;

    // Counter is XORed reversed into the top bits.
    always_comb begin
        w_lcnt_rev = '0;
        for (int k = 0; k < LCNT_W; k++) begin
            w_lcnt_rev[k] = lcnt_q[LCNT_W-1-k];
        end
    end

    // ---------------- inverse round ----------------
    spongent_player_inv #(.SPONGENT_B(SPONGENT_B)) u_player_inv (
        .in_x  (state_q),
        .out_x (w_pinv)
    );

    genvar n;
    generate
        for (n = 0; n < SPONGENT_B / 4; n++) begin : g_sbox_inv
            assign w_sinv[4*n +: 4] = sbox_inv(w_pinv[4*n +: 4]);
        end
    endgenerate

    always_comb begin
        w_inv_round = w_sinv;
        w_inv_round[LCNT_W-1:0]           = w_sinv[LCNT_W-1:0] ^ lcnt_q;
        w_inv_round[SPONGENT_B-1 -: LCNT_W] = w_sinv[SPONGENT_B-1 -: LCNT_W] ^ w_lcnt_rev;
    end

`ifdef SPONGENT_PERM_INV_FWD_EN
    // ---------------- forward round ----------------
    logic                  mode_q, mode_d;
    logic [SPONGENT_B-1:0] w_fx;
    logic [SPONGENT_B-1:0] w_fs;
    logic [SPONGENT_B-1:0] w_fwd_round;

    always_comb begin
        w_fx = state_q;
        w_fx[LCNT_W-1:0]             = state_q[LCNT_W-1:0] ^ lcnt_q;
        w_fx[SPONGENT_B-1 -: LCNT_W] = state_q[SPONGENT_B-1 -: LCNT_W] ^ w_lcnt_rev;
    end

    genvar j;
    generate
        for (n = 0; n < SPONGENT_B / 4; n++) begin : g_sbox_fwd
            assign w_fs[4*n +: 4] = sbox_fwd(w_fx[4*n +: 4]);
        end
        for (j = 0; j < SPONGENT_B - 1; j++) begin : g_player_fwd
            localparam int DST = (j * (SPONGENT_B / 4)) % (SPONGENT_B - 1);
            assign w_fwd_round[DST] = w_fs[j];
        end
    endgenerate
    assign w_fwd_round[SPONGENT_B-1] = w_fs[SPONGENT_B-1];
`endif

    // ---------------- control ----------------
    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        lcnt_d  = lcnt_q;
`ifdef SPONGENT_PERM_INV_FWD_EN
        mode_d  = mode_q;
`endif
        case (st_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = bus.data_in;
                    rnd_d   = RND_W'(SPONGENT_R - 1);
                    st_d    = ST_RUN;
`ifdef SPONGENT_PERM_INV_FWD_EN
                    mode_d  = bus.mode;
                    lcnt_d  = bus.mode ? LCNT_INIT : LCNT_LAST;
`else
                    lcnt_d  = LCNT_LAST;
`endif
                end
            end
            ST_RUN: begin
`ifdef SPONGENT_PERM_INV_FWD_EN
                state_d = mode_q ? w_fwd_round : w_inv_round;
                lcnt_d  = mode_q ? lfsr_fwd(lcnt_q) : lfsr_back(lcnt_q);
`else
                state_d = w_inv_round;
                lcnt_d  = lfsr_back(lcnt_q);
`endif
                if (rnd_q == '0) begin
                    st_d = ST_DONE;
                end else begin
                    rnd_d = rnd_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    st_d = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= ST_IDLE;
            state_q <= '0;
            rnd_q   <= '0;
            lcnt_q  <= '0;
`ifdef SPONGENT_PERM_INV_FWD_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
            lcnt_q  <= lcnt_d;
`ifdef SPONGENT_PERM_INV_FWD_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign bus.in_ready  = (st_q == ST_IDLE);
    assign bus.out_valid = (st_q == ST_DONE);
    assign bus.data_out  = state_q;
endmodule
`default_nettype wire

// File: tb/tb_spongent_perm_inv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spongent_perm_inv
//  Description : Self-checking bench for spongent_perm_inv. A behavioural
//                SPONGENT model (forward and inverse, table/array based)
//                supplies every expected value. Forward-mode steps are
//                compiled in when SPONGENT_PERM_INV_FWD_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spongent_perm_inv;
    localparam int B = 136;
    localparam int R = 70;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    spongent_perm_inv_if #(.SPONGENT_B(B)) bus ();

    spongent_perm_inv #(
        .SPONGENT_B (B),
        .SPONGENT_R (R),
        .LCNT_W     (7),
        .LCNT_INIT  (7'h7A)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int         sb [16] = '{14, 13, 11, 0, 2, 1, 4, 15, 7, 10, 8, 5, 9, 12, 3, 6};
    int         sbi[16];
    logic [6:0] lc [R];

    function automatic logic [B-1:0] add_cnt(input logic [B-1:0] x, input logic [6:0] c);
        logic [B-1:0] y;
        y = x;
        for (int k = 0; k < 7; k++) begin
            y[k]       = y[k] ^ c[k];
            y[B-1-k]   = y[B-1-k] ^ c[k];
        end
        return y;
    endfunction

    function automatic logic [B-1:0] model_fwd(input logic [B-1:0] x0);
        logic [B-1:0] x, y;
        x = x0;
        for (int r = 0; r < R; r++) begin
            x = add_cnt(x, lc[r]);
            for (int m = 0; m < B / 4; m++) x[4*m +: 4] = 4'(sb[x[4*m +: 4]]);
            for (int j = 0; j < B - 1; j++) y[(j * B / 4) % (B - 1)] = x[j];
            y[B-1] = x[B-1];
            x = y;
        end
        return x;
    endfunction

    function automatic logic [B-1:0] model_inv(input logic [B-1:0] x0);
        logic [B-1:0] x, y;
        x = x0;
        for (int r = R - 1; r >= 0; r--) begin
            for (int j = 0; j < B - 1; j++) y[j] = x[(j * B / 4) % (B - 1)];
            y[B-1] = x[B-1];
            for (int m = 0; m < B / 4; m++) y[4*m +: 4] = 4'(sbi[y[4*m +: 4]]);
            x = add_cnt(y, lc[r]);
        end
        return x;
    endfunction

    function automatic logic [B-1:0] rand_state();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[B-1:0];
    endfunction

    // ---------------- check / drive helpers ----------------
    task automatic check(input string tag, input logic [B-1:0] got, input logic [B-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accept edge.
    task automatic start(input logic [B-1:0] x);
        check("in_ready_idle", B'(bus.in_ready), B'(1));
        bus.in_valid = 1'b1;
        bus.data_in  = x;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.out_valid && lat < 200);
    endtask

    task automatic take(output logic [B-1:0] y);
        y = bus.data_out;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("in_ready_after_hs", B'(bus.in_ready), B'(1));
        check("out_valid_after_hs", B'(bus.out_valid), B'(0));
    endtask

    task automatic run(input logic [B-1:0] x, output logic [B-1:0] y);
        int lat;
        start(x);
        wait_out(lat);
        check("latency", B'(lat), B'(R));
        take(y);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [B-1:0] x, x2, y, z, exp;
        int           lat;

        checks   = 0;
        failures = 0;
        for (int v = 0; v < 16; v++) sbi[sb[v]] = v;
        lc[0] = 7'h7A;
        for (int r = 1; r < R; r++) lc[r] = {lc[r-1][5:0], lc[r-1][6] ^ lc[r-1][5]};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
`ifdef SPONGENT_PERM_INV_FWD_EN
        bus.mode      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", B'(bus.in_ready), B'(1));
        check("rst_out_valid", B'(bus.out_valid), B'(0));
        check("rst_data_out", bus.data_out, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Round trip: inverse of the forward permutation returns the input.
        for (int t = 0; t < 4; t++) begin
            x = rand_state();
            run(model_fwd(x), y);
            check("round_trip", y, x);
        end

        // All-zero input.
        run('0, y);
        check("zero_input", y, model_inv('0));

        // All-ones input.
        run('1, y);
        check("ones_input", y, model_inv('1));

        // Random direct inverse.
        x = rand_state();
        run(x, y);
        check("random_inv", y, model_inv(x));

        // Backpressure: result held while out_ready stays low.
        x   = rand_state();
        exp = model_inv(x);
        start(x);
        wait_out(lat);
        check("bp_latency", B'(lat), B'(R));
        repeat (10) begin
            check("bp_out_valid", B'(bus.out_valid), B'(1));
            check("bp_data_out", bus.data_out, exp);
            check("bp_in_ready", B'(bus.in_ready), B'(0));
            @(posedge clk); #1;
        end
        take(y);
        check("bp_result", y, exp);

        // in_valid pulsed during RUN with a different state is ignored.
        x  = rand_state();
        x2 = rand_state();
        start(x);
        repeat (20) @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.data_in  = x2;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_out(lat);
        check("ign_latency", B'(lat), B'(R - 21));
        take(y);
        check("ign_result", y, model_inv(x));

        // Reset in the middle of a run.
        x = rand_state();
        start(x);
        repeat (35) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", B'(bus.in_ready), B'(1));
        check("midrst_out_valid", B'(bus.out_valid), B'(0));
        check("midrst_data_out", bus.data_out, '0);
        run(x, y);
        check("midrst_fresh_run", y, model_inv(x));

`ifdef SPONGENT_PERM_INV_FWD_EN
        // Forward mode, then inverse mode on its result.
        x = rand_state();
        bus.mode = 1'b1;
        run(x, y);
        check("fwd_result", y, model_fwd(x));
        bus.mode = 1'b0;
        run(y, z);
        check("fwd_inv_round_trip", z, x);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
